// File: rtl/dest_map_slice.sv
// dest_map_slice
//   AXI-Stream register slice that remaps a packet's tdest into tuser.
//   The mapped value is taken from C_MAP_TABLE at the first beat of each
//   packet and applied to every beat of that packet.
//   It is built as a two-entry skid buffer, so every master output and
//   s_axis_tready come straight from flops.
//
// Optional feature (macro DEST_MAP_SLICE_DROP_EN):
//   A packet whose first beat has tdest >= C_NUM_VALID_DEST is accepted
//   and discarded in full.
//   With the macro undefined, such packets are forwarded and mapped like
//   any other packet.
//
// Ports
//   clk            : clock, rising edge
//   rstn           : asynchronous active-low reset
//   s_axis_tdata   : slave data         s_axis_tkeep  : slave byte enables
//   s_axis_tvalid  : slave valid        s_axis_tlast  : slave end of packet
//   s_axis_tdest   : slave destination  s_axis_tready : slave ready (registered)
//   m_axis_tdata   : master data        m_axis_tkeep  : master byte enables
//   m_axis_tvalid  : master valid       m_axis_tlast  : master end of packet
//   m_axis_tuser   : mapped destination m_axis_tready : master ready
module dest_map_slice #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH/8,
  parameter int C_AXIS_TDEST_WIDTH = 2,
  parameter int C_AXIS_TUSER_WIDTH = 2,
  parameter logic [(2**C_AXIS_TDEST_WIDTH)*C_AXIS_TUSER_WIDTH-1:0] C_MAP_TABLE = 8'hE4,
  parameter int C_NUM_VALID_DEST   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic [C_AXIS_TDEST_WIDTH-1:0] s_axis_tdest,
  output logic                          s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  input  logic                          m_axis_tready
);

  // One buffered beat: {tdata, tkeep, tlast, tuser}
  localparam int BEAT_W = C_AXIS_TDATA_WIDTH + C_AXIS_TKEEP_WIDTH + 1 + C_AXIS_TUSER_WIDTH;

`ifdef DEST_MAP_SLICE_DROP_EN
  typedef enum logic [1:0] {ST_SOP, ST_BODY, ST_DROP} state_t;
`else
  typedef enum logic {ST_SOP, ST_BODY} state_t;
`endif

  state_t                        state_q, state_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] user_q, user_d;
  logic                          m_vld_q, m_vld_d;
  logic [BEAT_W-1:0]             m_beat_q, m_beat_d;
  logic                          sk_vld_q, sk_vld_d;
  logic [BEAT_W-1:0]             sk_beat_q, sk_beat_d;
  logic                          rdy_q, rdy_d;

  logic                          accept, discard, push, out_free;
  logic                          dest_invalid;
  logic [C_AXIS_TUSER_WIDTH-1:0] map_user, beat_user;
  logic [BEAT_W-1:0]             in_beat;

  assign map_user     = C_MAP_TABLE[32'(s_axis_tdest)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
  assign dest_invalid = (32'(s_axis_tdest) >= 32'(C_NUM_VALID_DEST));

`ifndef DEST_MAP_SLICE_DROP_EN
  // Invalid destinations are simply forwarded in this build.
  logic unused_dest_invalid;
  assign unused_dest_invalid = dest_invalid;
`endif

  // The first beat of a packet uses its own tdest; later beats reuse the latched mapping.
  assign beat_user = (state_q == ST_SOP) ? map_user : user_q;
  assign in_beat   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, beat_user};
  assign accept    = s_axis_tvalid & rdy_q;

  // Packet FSM
  always_comb begin
    state_d = state_q;
    user_d  = user_q;
    discard = 1'b0;
    if (accept) begin
      case (state_q)
        ST_SOP: begin
          user_d  = map_user;
          state_d = s_axis_tlast ? ST_SOP : ST_BODY;
`ifdef DEST_MAP_SLICE_DROP_EN
          if (dest_invalid) begin
            discard = 1'b1;
            state_d = s_axis_tlast ? ST_SOP : ST_DROP;
          end
`endif
        end
        ST_BODY: state_d = s_axis_tlast ? ST_SOP : ST_BODY;
`ifdef DEST_MAP_SLICE_DROP_EN
        ST_DROP: begin
          discard = 1'b1;
          state_d = s_axis_tlast ? ST_SOP : ST_DROP;
        end
        default: state_d = ST_SOP;
`endif
      endcase
    end
  end

  // Skid buffer
  assign push     = accept & ~discard;
  assign out_free = ~m_vld_q | m_axis_tready;

  always_comb begin
    m_vld_d   = m_vld_q;
    m_beat_d  = m_beat_q;
    sk_vld_d  = sk_vld_q;
    sk_beat_d = sk_beat_q;
    if (out_free) begin
      if (sk_vld_q) begin
        // The older beat in the skid entry goes out first.
        m_vld_d  = 1'b1;
        m_beat_d = sk_beat_q;
        sk_vld_d = push;
        if (push) sk_beat_d = in_beat;
      end else begin
        m_vld_d = push;
        if (push) m_beat_d = in_beat;
      end
    end else if (push) begin
      sk_vld_d  = 1'b1;
      sk_beat_d = in_beat;
    end
    // Ready drops only when both entries are full.
    // While dropping, beats never reach the buffer, so ready stays high.
    rdy_d = ~sk_vld_d;
`ifdef DEST_MAP_SLICE_DROP_EN
    if (state_d == ST_DROP) rdy_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_SOP;
      user_q    <= '0;
      m_vld_q   <= 1'b0;
      m_beat_q  <= '0;
      sk_vld_q  <= 1'b0;
      sk_beat_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      user_q    <= user_d;
      m_vld_q   <= m_vld_d;
      m_beat_q  <= m_beat_d;
      sk_vld_q  <= sk_vld_d;
      sk_beat_q <= sk_beat_d;
      rdy_q     <= rdy_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = m_vld_q;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = m_beat_q;

endmodule
